// File: rtl/door_pkg.sv
// Shared types and default timing constants for the parking-gate door controller.
package door_pkg;

   typedef enum logic [1:0] {
      CLOSED = 2'b00,
      OPEN   = 2'b01,
      WARN   = 2'b10
   } door_state_t;

   localparam int DEF_OPEN_CYCLES = 10;
   localparam int DEF_WARN_CYCLES = 4;
   localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/door_if.sv
// Request/indicator pair between the access logic (master) and the door controller (slave).
interface door_if;
   logic open_signal;
   logic DoorLED;

   modport master (output open_signal, input DoorLED);
   modport slave  (input open_signal, output DoorLED);
endinterface

// File: rtl/door_timer.sv
// Loadable down-counter that holds at zero; zero flag feeds the door FSM.
module door_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk_2Hz,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk_2Hz) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/door_controller.sv
// Parking-gate door controller: OPEN hold, WARN pre-close, then automatic close.
// Optional macro DOOR_BLINK_EN makes DoorLED toggle during WARN (first WARN cycle 0).
//
// state  | meaning
// CLOSED | door shut, LED 0, waiting for a request
// OPEN   | door open, LED 1, hold timer running (retriggerable)
// WARN   | about to close, LED 1 or blinking, request reopens
module door_controller
   import door_pkg::*;
#(
   parameter int OPEN_CYCLES = DEF_OPEN_CYCLES,
   parameter int WARN_CYCLES = DEF_WARN_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic  clk_2Hz,
   input  logic  reset,
   door_if.slave door
);

   localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_CYCLES - 1);
   localparam logic [CNT_W-1:0] WARN_LOAD = CNT_W'(WARN_CYCLES - 1);

`ifdef DOOR_BLINK_EN
   localparam logic BLINK = 1'b1;
`else
   localparam logic BLINK = 1'b0;
`endif

   door_state_t      r_state;
   logic             r_led;
   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic             w_en;
   logic             w_zero;
   logic             w_open;

   assign w_open = door.open_signal;

   // Timer loads only on state entry or retrigger; otherwise counts down.
   always_comb begin
      w_load     = 1'b0;
      w_load_val = OPEN_LOAD;
      w_en       = 1'b0;
      case (r_state)
         CLOSED: w_load = w_open;
         OPEN: begin
            if (w_open) begin
               w_load = 1'b1;
            end else if (w_zero) begin
               w_load     = 1'b1;
               w_load_val = WARN_LOAD;
            end else begin
               w_en = 1'b1;
            end
         end
         WARN: begin
            if (w_open) begin
               w_load = 1'b1;
            end else begin
               w_en = ~w_zero;
            end
         end
         default: ;
      endcase
   end

   door_timer #(.CNT_W(CNT_W)) u_timer (
      .clk_2Hz    (clk_2Hz),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_en       (w_en),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk_2Hz) begin
      if (reset) begin
         r_state <= CLOSED;
         r_led   <= 1'b0;
      end else begin
         case (r_state)
            CLOSED: begin
               if (w_open) begin
                  r_state <= OPEN;
                  r_led   <= 1'b1;
               end
            end
            OPEN: begin
               r_led <= 1'b1;
               if (!w_open && w_zero) begin
                  r_state <= WARN;
                  r_led   <= ~BLINK;
               end
            end
            WARN: begin
               if (w_open) begin
                  r_state <= OPEN;
                  r_led   <= 1'b1;
               end else if (w_zero) begin
                  r_state <= CLOSED;
                  r_led   <= 1'b0;
               end else begin
                  r_led <= BLINK ? ~r_led : 1'b1;
               end
            end
            default: begin
               r_state <= CLOSED;
               r_led   <= 1'b0;
            end
         endcase
      end
   end

   assign door.DoorLED = r_led;

endmodule

// File: tb/tb_door_controller.sv
// Scoreboard bench for door_controller: expected DoorLED pushed per driven cycle, popped after the edge.
module tb_door_controller;

   localparam int OC = 10;
   localparam int WC = 4;

   logic clk_2Hz = 1'b0;
   logic reset   = 1'b1;

   door_if u_if ();

   door_controller #(.OPEN_CYCLES(OC), .WARN_CYCLES(WC), .CNT_W(8)) dut (
      .clk_2Hz (clk_2Hz),
      .reset   (reset),
      .door    (u_if.slave)
   );

   always #5 clk_2Hz = ~clk_2Hz;

   logic exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   rem   = 0;   // cycles of open indication still owed after this edge

   function automatic logic model_led(input int r);
      if (r <= 0) return 1'b0;
`ifdef DOOR_BLINK_EN
      if (r <= WC) return ((WC - r) % 2) == 1;
`endif
      return 1'b1;
   endfunction

   task automatic step(input logic op, input logic rs, input string tag);
      logic exp_v;
      logic got;
      @(negedge clk_2Hz);
      u_if.open_signal = op;
      reset            = rs;
      if (rs)      rem = 0;
      else if (op) rem = OC + WC;
      else if (rem > 0) rem = rem - 1;
      exp_q.push_back(model_led(rem));
      @(posedge clk_2Hz);
      #1;
      got   = u_if.DoorLED;
      exp_v = exp_q.pop_front();
      total++;
      assert (got === exp_v) else begin
         bad++;
         $error("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp_v);
      end
   endtask

   initial begin
      u_if.open_signal = 1'b1;
      // reset wins over a standing request
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "reset");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "idle");

      // single one-cycle request
      step(1'b1, 1'b0, "pulse");
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "pulse_run");

      // retrigger in WARN at cycle 12
      step(1'b1, 1'b0, "retrig_a");
      for (int i = 0; i < 11; i++) step(1'b0, 1'b0, "retrig_mid");
      step(1'b1, 1'b0, "retrig_b");
      for (int i = 0; i < 18; i++) step(1'b0, 1'b0, "retrig_run");

      // held request
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, "held");
      for (int i = 0; i < 18; i++) step(1'b0, 1'b0, "held_rel");

      // reset mid-OPEN and mid-WARN
      step(1'b1, 1'b0, "rstopen_p");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "rstopen_run");
      step(1'b0, 1'b1, "rstopen_rst");
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, "rstopen_after");
      step(1'b1, 1'b0, "rstwarn_p");
      for (int i = 0; i < 11; i++) step(1'b0, 1'b0, "rstwarn_run");
      step(1'b0, 1'b1, "rstwarn_rst");
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "rstwarn_after");

      // random requests against the model
      for (int i = 0; i < 200; i++)
         step(($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0), "rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
